// File: rtl/axis_rle_encoder.sv
// axis_rle_encoder: collapses runs of identical AXI4-Stream payloads into
// single words whose count field [W-17:W-32] carries run length minus one.
// Optional idle-flush of an open run is enabled by defining the macro
// AXIS_RLE_ENCODER_TIMEOUT_EN (threshold set by TIMEOUT_CYCLES).
module axis_rle_encoder #(
  parameter int AXIS_TDATA_WIDTH = 128,  // must be >= 32
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);

  localparam int W       = AXIS_TDATA_WIDTH;
  localparam int CNT_LSB = W - 32;
  localparam logic [W-1:0] CNT_MASK = {{(W-16){1'b0}}, 16'hFFFF} << CNT_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no open run
    RUN  = 2'd1,  // run open and still allowed to grow
    PEND = 2'd2   // closed tlast run waiting for the output slot
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   run_payload_reg, run_payload_next;
  logic [15:0]    run_count_reg, run_count_next;
  logic           run_last_reg, run_last_next;

  logic           emit;
  logic [W-1:0]   emit_data;
  logic           emit_last;
  logic           slot_free;
  logic           accept;
  logic           same;
  logic [W-1:0]   payload;

  // Insert a 16-bit count into an already-masked payload.
  function automatic logic [W-1:0] pack_word(input logic [W-1:0] p, input logic [15:0] c);
    return p | ({{(W-16){1'b0}}, c} << CNT_LSB);
  endfunction

  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = aresetn && slot_free && (state_reg != PEND);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign payload       = s_axis_tdata & ~CNT_MASK;
  assign same          = (payload == run_payload_reg);

`ifdef AXIS_RLE_ENCODER_TIMEOUT_EN
  logic [15:0] idle_cnt_reg;
  logic        timeout_hit;

  assign timeout_hit = (idle_cnt_reg == 16'(TIMEOUT_CYCLES));

  // Count consecutive RUN cycles with no accepted beat; saturate at the threshold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idle_cnt_reg <= 16'd0;
    end else if (state_reg != RUN || accept || (timeout_hit && slot_free)) begin
      idle_cnt_reg <= 16'd0;
    end else if (!timeout_hit) begin
      idle_cnt_reg <= idle_cnt_reg + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
`endif

  // Next-state, run update and emit decision.
  always_comb begin
    state_next       = state_reg;
    run_payload_next = run_payload_reg;
    run_count_next   = run_count_reg;
    run_last_next    = run_last_reg;
    emit             = 1'b0;
    emit_data        = pack_word(run_payload_reg, run_count_reg);
    emit_last        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          run_payload_next = payload;
          run_count_next   = 16'd0;
          run_last_next    = s_axis_tlast;
          if (s_axis_tlast) begin
            // single-beat packet: emit at once, no run stays open
            emit      = 1'b1;
            emit_data = payload;
            emit_last = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (same && run_count_reg != 16'hFFFF) begin
            run_count_next = run_count_reg + 16'd1;
            if (s_axis_tlast) begin
              emit          = 1'b1;
              emit_data     = pack_word(run_payload_reg, run_count_reg + 16'd1);
              emit_last     = 1'b1;
              run_last_next = 1'b1;
              state_next    = IDLE;
            end
          end else begin
            // differing payload or saturated count closes the old run
            emit             = 1'b1;
            run_payload_next = payload;
            run_count_next   = 16'd0;
            run_last_next    = s_axis_tlast;
            state_next       = s_axis_tlast ? PEND : RUN;
          end
        end
`ifdef AXIS_RLE_ENCODER_TIMEOUT_EN
        else if (timeout_hit && slot_free) begin
          emit       = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      PEND: begin
        if (slot_free) begin
          emit       = 1'b1;
          emit_last  = run_last_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and open-run register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      run_payload_reg <= '0;
      run_count_reg   <= 16'd0;
      run_last_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      run_payload_reg <= run_payload_next;
      run_count_reg   <= run_count_next;
      run_last_reg    <= run_last_next;
    end
  end

  // Single output slot: load on emit, clear valid when drained.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (emit) begin
      m_axis_tdata  <= emit_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= emit_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rle_encoder.sv
// Directed self-checking bench for axis_rle_encoder (W = 128, TIMEOUT_CYCLES = 16).
`timescale 1ns/1ps
module tb_axis_rle_encoder;

  localparam int W = 128;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;
  int stall_cnt = 0;
  bit bp_done = 1'b0;
  logic [W:0] out_q[$];  // {tlast, tdata} of every output handshake

  always #5 aclk = ~aclk;

  axis_rle_encoder #(
    .AXIS_TDATA_WIDTH(W),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  // Record output handshakes and input stalls mid-cycle.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      out_q.push_back({m_axis_tlast, m_axis_tdata});
      $display("out: tlast=%0b tdata=%h", m_axis_tlast, m_axis_tdata);
    end
    if (aresetn && s_axis_tvalid && !s_axis_tready) stall_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Encoded word built straight from the field layout.
  function automatic logic [W-1:0] word(input logic [W-1:0] raw, input logic [15:0] cnt);
    return {raw[127:112], cnt, raw[95:0]};
  endfunction

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        acc = 1'b1;
        break;
      end
      @(posedge aclk); #1;
    end
    if (!acc) begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: beat %h not accepted, required accept within 1000 cycles", d);
    end
    @(posedge aclk); #1;
  endtask

  task automatic go_idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
    n_checks++;
    if (m_axis_tdata !== '0) begin n_fails++; $display("FAIL reset_tdata: got %h required 0", m_axis_tdata); end
    n_checks++;
    if (m_axis_tlast !== 1'b0) begin n_fails++; $display("FAIL reset_tlast: got %b required 0", m_axis_tlast); end
    n_checks++;
    if (s_axis_tready !== 1'b0) begin n_fails++; $display("FAIL reset_tready_low: got %b required 0", s_axis_tready); end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b1) begin n_fails++; $display("FAIL reset_tready_release: got %b required 1", s_axis_tready); end
    @(posedge aclk); #1;
  endtask

  task automatic test_run_then_change();
    logic [W-1:0] a, b, c;
    logic [W:0] exp [3];
    logic [W:0] got;
    a = {32{4'hA}};
    b = {32{4'hB}};
    c = {32{4'hC}};
    exp[0] = {1'b0, word(a, 16'd4)};
    exp[1] = {1'b1, word(b, 16'd0)};
    exp[2] = {1'b1, word(c, 16'd0)};
    out_q.delete();
    stall_cnt = 0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(a, 1'b0);
    send_beat(b, 1'b1);
    send_beat(c, 1'b1);
    go_idle();
    wait_cycles(5);
    n_checks++;
    if (out_q.size() != 3) begin n_fails++; $display("FAIL run_words: got %0d words required 3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      n_checks++;
      if (got !== exp[i]) begin n_fails++; $display("FAIL run_word%0d: got %h required %h", i, got, exp[i]); end
    end
    n_checks++;
    if (stall_cnt != 1) begin n_fails++; $display("FAIL pend_stall: got %0d stall cycles required 1", stall_cnt); end
  endtask

  task automatic test_count_field_ignored();
    logic [W-1:0] d;
    logic [W:0] exp [2];
    logic [W:0] got;
    exp[0] = {1'b0, word(128'h1, 16'd1)};
    exp[1] = {1'b1, word(128'h2, 16'd2)};
    out_q.delete();
    for (int i = 0; i < 5; i++) begin
      d = (i < 2) ? 128'h1 : 128'h2;
      d[111:96] = 16'($urandom);
      send_beat(d, i == 4);
    end
    go_idle();
    wait_cycles(5);
    n_checks++;
    if (out_q.size() != 2) begin n_fails++; $display("FAIL field_words: got %0d words required 2", out_q.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      n_checks++;
      if (got !== exp[i]) begin n_fails++; $display("FAIL field_word%0d: got %h required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] x;
    logic [W:0] exp [2];
    logic [W:0] got;
    x = 128'h0123_4567_0000_0000_89AB_CDEF_1357_9BDF;
    exp[0] = {1'b0, word(x, 16'hFFFF)};
    exp[1] = {1'b1, word(x, 16'd1)};
    out_q.delete();
    for (int i = 0; i < 65537; i++) send_beat(x, 1'b0);
    send_beat(x, 1'b1);
    go_idle();
    wait_cycles(5);
    n_checks++;
    if (out_q.size() != 2) begin n_fails++; $display("FAIL sat_words: got %0d words required 2", out_q.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      n_checks++;
      if (got !== exp[i]) begin n_fails++; $display("FAIL sat_word%0d: got %h required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p, q;
    logic [W:0] got, e;
    p = {16{8'h5A}};
    q = {16{8'hC3}};
    out_q.delete();
    bp_done = 1'b0;
    m_axis_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat((i % 2 == 1) ? q : p, i == 7);
        go_idle();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge aclk); #1;
          m_axis_tready = ~m_axis_tready;
        end
      end
      begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (!bp_done) begin
          @(negedge aclk);
          if (prev_stall) begin
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
              n_fails++;
              $display("FAIL bp_stable: got valid=%b data=%h required valid=1 data=%h", m_axis_tvalid, m_axis_tdata, prev_data);
            end
          end
          if (m_axis_tvalid && !m_axis_tready) begin
            n_checks++;
            if (s_axis_tready !== 1'b0) begin n_fails++; $display("FAIL bp_tready: got %b required 0 while slot full", s_axis_tready); end
          end
          prev_stall = m_axis_tvalid && !m_axis_tready;
          prev_data  = m_axis_tdata;
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_cycles(6);
    n_checks++;
    if (out_q.size() != 8) begin n_fails++; $display("FAIL bp_words: got %0d words required 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 'x;
      e = {(i == 7), word((i % 2 == 1) ? q : p, 16'd0)};
      n_checks++;
      if (got !== e) begin n_fails++; $display("FAIL bp_word%0d: got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] r, s, t;
    logic [W:0] got, e;
    r = {8{16'h7E7E}};
    s = {8{16'h1111}};
    t = {8{16'h2468}};
    out_q.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(r, 1'b0);
    send_beat(s, 1'b0);
    go_idle();
    @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word(r, 16'd7)) begin
      n_fails++;
      $display("FAIL mid_pending: got valid=%b data=%h required valid=1 data=%h", m_axis_tvalid, m_axis_tdata, word(r, 16'd7));
    end
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL mid_reset_tvalid: got %b required 0", m_axis_tvalid); end
    n_checks++;
    if (s_axis_tready !== 1'b0) begin n_fails++; $display("FAIL mid_reset_tready: got %b required 0", s_axis_tready); end
    @(posedge aclk);
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    send_beat(t, 1'b1);
    go_idle();
    wait_cycles(5);
    e = {1'b1, word(t, 16'd0)};
    n_checks++;
    if (out_q.size() != 1) begin n_fails++; $display("FAIL mid_words: got %0d words required 1", out_q.size()); end
    got = (out_q.size() > 0) ? out_q[0] : 'x;
    n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL mid_word: got %h required %h", got, e); end
  endtask

  task automatic test_timeout();
    logic [W-1:0] x;
    x = {4{32'hDEAD_BEEF}};
    out_q.delete();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(x, 1'b0);
    go_idle();
`ifdef AXIS_RLE_ENCODER_TIMEOUT_EN
    repeat (16) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL timeout_early: got valid %b required 0 at 16 cycles", m_axis_tvalid); end
    @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== word(x, 16'd2) || m_axis_tlast !== 1'b0) begin
      n_fails++;
      $display("FAIL timeout_flush: got valid=%b last=%b data=%h required valid=1 last=0 data=%h",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, word(x, 16'd2));
    end
`else
    repeat (40) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (out_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
      n_fails++;
      $display("FAIL no_timeout: got %0d words valid=%b required 0 words valid=0", out_q.size(), m_axis_tvalid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_run_then_change();
    test_count_field_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_saturation();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
